// File: rtl/mem_pic_writer_pkg.sv
// Shared types and helpers for the picture-memory writer.
// Optional feature macro: MEM_PIC_WRITER_CHECKSUM_EN (see mem_pic_writer.sv).
package mem_pic_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Width of one packed storage word.
  function automatic int word_w(input int size);
    return LANES * size;
  endfunction

  // Byte address to word index relative to the memory base; low bits drop out.
  function automatic logic [31:0] addr_to_word(input logic [31:0] addr,
                                               input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/mem_pic_writer_if.sv
// Pixel stream handshake into the picture-memory writer.
interface mem_pic_writer_if #(parameter int SIZE = 8);
  logic [SIZE-1:0] PIX_DATA;
  logic            PIX_VALID;
  logic            PIX_READY;

  modport master (output PIX_DATA, PIX_VALID, input PIX_READY);
  modport slave  (input PIX_DATA, PIX_VALID, output PIX_READY);
endinterface

// File: rtl/mem_pic_ram.sv
// Synchronous RAM: one write port, one registered read port.
// A read and a write to the same word on one edge return the old contents.
module mem_pic_ram #(
  parameter int W     = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          rd_ok_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Storage array; deliberately never reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read; out-of-range addresses read as zero.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)     rdata_o <= '0;
    else if (rd_ok_i) rdata_o <= mem_q[raddr_i];
    else              rdata_o <= '0;
  end

endmodule

// File: rtl/mem_pic_writer.sv
// Picture-memory writer: packs a pixel stream four-per-word into RAM and
// offers a registered readback port.
// Optional: define MEM_PIC_WRITER_CHECKSUM_EN to add a CHECKSUM output that
// sums every accepted pixel.
module mem_pic_writer
  import mem_pic_pkg::*;
#(
  parameter int          SIZE        = 8,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      START,
  input  logic [31:0]               PIX_COUNT,
  mem_pic_writer_if.slave           pix,
  input  logic [31:0]               RD_ADDRESS,
  output logic [word_w(SIZE)-1:0]   RD_DATA,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      ERROR
`ifdef MEM_PIC_WRITER_CHECKSUM_EN
  ,
  output logic [31:0]               CHECKSUM
`endif
);

  localparam int          WW  = word_w(SIZE);
  localparam int          AW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] CAP = 33'(LANES * DEPTH_WORDS);

  state_e                           state_q, state_d;
  logic [1:0]                       lane_q, lane_d;
  logic [AW-1:0]                    widx_q, widx_d;
  logic [31:0]                      cnt_q, cnt_d;
  logic [31:0]                      total_q, total_d;
  logic [LANES-2:0][SIZE-1:0]       buf_q, buf_d;
  logic                             err_q, err_d;
  logic                             acc;
  logic                             we;
  logic [WW-1:0]                    wdata;
  logic [31:0]                      rd_word;
  logic                             rd_ok;
`ifdef MEM_PIC_WRITER_CHECKSUM_EN
  logic [31:0]                      sum_q, sum_d;
`endif

  assign acc           = (state_q == S_FILL) && pix.PIX_VALID;
  assign pix.PIX_READY = (state_q == S_FILL);
  assign BUSY          = (state_q == S_FILL) || (state_q == S_FLUSH);
  assign DONE          = (state_q == S_DONE);
  assign ERROR         = err_q;

  // Next-state, lane packing and write-port control.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    widx_d  = widx_q;
    cnt_d   = cnt_q;
    total_d = total_q;
    buf_d   = buf_q;
    err_d   = err_q;
    we      = 1'b0;
    wdata   = '0;
`ifdef MEM_PIC_WRITER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
`ifdef MEM_PIC_WRITER_CHECKSUM_EN
          sum_d = '0;
`endif
          if (PIX_COUNT == 32'd0) begin
            state_d = S_DONE;
            err_d   = 1'b0;
          end else if ({1'b0, PIX_COUNT} > CAP) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_FILL;
            err_d   = 1'b0;
            widx_d  = '0;
            lane_d  = '0;
            cnt_d   = '0;
            total_d = PIX_COUNT;
          end
        end
      end
      S_FILL: begin
        if (acc) begin
          cnt_d = cnt_q + 32'd1;
`ifdef MEM_PIC_WRITER_CHECKSUM_EN
          sum_d = sum_q + 32'(pix.PIX_DATA);
`endif
          if (lane_q == 2'd3) begin
            we     = 1'b1;
            wdata  = {pix.PIX_DATA, buf_q};
            widx_d = widx_q + AW'(1);
            lane_d = 2'd0;
          end else begin
            for (int k = 0; k < LANES - 1; k++)
              if (lane_q == 2'(k)) buf_d[k] = pix.PIX_DATA;
            lane_d = lane_q + 2'd1;
          end
          // A last pixel in lane 3 was just written; otherwise pad it out.
          if (cnt_q + 32'd1 == total_q)
            state_d = (lane_q == 2'd3) ? S_DONE : S_FLUSH;
        end
      end
      S_FLUSH: begin
        // lane_q counts the filled lanes; stale buffer lanes read as zero.
        we = 1'b1;
        for (int k = 0; k < LANES - 1; k++)
          if (2'(k) < lane_q) wdata[k*SIZE +: SIZE] = buf_q[k];
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      lane_q  <= '0;
      widx_q  <= '0;
      cnt_q   <= '0;
      total_q <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      widx_q  <= widx_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

`ifdef MEM_PIC_WRITER_CHECKSUM_EN
  // Running pixel sum.
  always_ff @(posedge CLK) begin
    if (!RESET) sum_q <= '0;
    else        sum_q <= sum_d;
  end
  assign CHECKSUM = sum_q;
`endif

  assign rd_word = addr_to_word(RD_ADDRESS, BASE_ADDR);
  assign rd_ok   = (RD_ADDRESS >= BASE_ADDR) && (rd_word < 32'(DEPTH_WORDS));

  // Reset abandons the frame at once, so it also blocks a write on that edge.
  mem_pic_ram #(.W(WW), .DEPTH(DEPTH_WORDS), .AW(AW)) u_ram (
    .clk_i   (CLK),
    .rst_n_i (RESET),
    .we_i    (we && RESET),
    .waddr_i (widx_q),
    .wdata_i (wdata),
    .rd_ok_i (rd_ok),
    .raddr_i (rd_word[AW-1:0]),
    .rdata_o (RD_DATA)
  );

endmodule

// File: tb/tb_mem_pic_writer.sv
// Self-checking bench for mem_pic_writer against a word-array picture model.
module tb_mem_pic_writer;
  import mem_pic_pkg::*;

  localparam int          SIZE  = 8;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        START = 1'b0;
  logic [31:0] PIX_COUNT = '0;
  logic [31:0] RD_ADDRESS = '0;
  logic [31:0] RD_DATA;
  logic        BUSY, DONE, ERROR;
`ifdef MEM_PIC_WRITER_CHECKSUM_EN
  logic [31:0] CHECKSUM;
`endif

  mem_pic_writer_if #(.SIZE(SIZE)) pix ();

  mem_pic_writer #(.SIZE(SIZE), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .START      (START),
    .PIX_COUNT  (PIX_COUNT),
    .pix        (pix),
    .RD_ADDRESS (RD_ADDRESS),
    .RD_DATA    (RD_DATA),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ERROR      (ERROR)
`ifdef MEM_PIC_WRITER_CHECKSUM_EN
    ,
    .CHECKSUM   (CHECKSUM)
`endif
  );

  always #5 CLK = ~CLK;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] mdl [DEPTH];
  bit          mok [DEPTH];
  logic [31:0] msum = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Read one word back by byte address (random low bits must be ignored).
  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    RD_ADDRESS = addr;
    tick();
    chk(tag, RD_DATA, exp);
  endtask

  task automatic sweep();
    for (int w = 0; w < DEPTH; w++)
      if (mok[w]) rd("sweep", BASE + 32'(4 * w) + 32'($urandom_range(0, 3)), mdl[w]);
    rd("oor_hi", BASE + 32'(4 * DEPTH), 32'h0);
    rd("oor_lo", BASE - 32'd4, 32'h0);
  endtask

  // stall: 0 = valid held high, 1 = valid low every other cycle, 2 = random gaps
  task automatic run_frame(input logic [7:0] px[$], input int stall);
    int n = px.size();
    int i = 0;
    int cyc = 0;
    logic [31:0] word;
    bit v;
    PIX_COUNT = 32'(n);
    START = 1'b1;
    tick();
    START = 1'b0;
    msum = '0;
    while (i < n && cyc < 20 * n + 20) begin
      case (stall)
        1:       v = (cyc % 2) == 1;
        2:       v = $urandom_range(0, 2) != 0;
        default: v = 1'b1;
      endcase
      pix.PIX_VALID = v;
      pix.PIX_DATA  = v ? px[i] : 8'($urandom);
      RD_ADDRESS    = BASE + 32'(4 * (i / 4));
      chk("fill_ready", pix.PIX_READY, 1'b1);
      chk("fill_busy", BUSY, 1'b1);
      tick();
      // Memory is updated in the model only after the frame: old contents.
      if (mok[i / 4]) chk("rd_old", RD_DATA, mdl[i / 4]);
      if (v) begin
        msum = msum + 32'(px[i]);
        i++;
      end
      cyc++;
    end
    pix.PIX_VALID = 1'b0;
    if (n % 4 != 0) begin
      chk("flush_ready", pix.PIX_READY, 1'b0);
      chk("flush_busy", BUSY, 1'b1);
      chk("flush_done", DONE, 1'b0);
      tick();
    end
    chk("end_done", DONE, 1'b1);
    chk("end_busy", BUSY, 1'b0);
    chk("end_error", ERROR, 1'b0);
    tick();
    chk("end_done2", DONE, 1'b1);
`ifdef MEM_PIC_WRITER_CHECKSUM_EN
    chk("checksum", CHECKSUM, msum);
`endif
    for (int w = 0; w < (n + 3) / 4; w++) begin
      word = '0;
      for (int k = 0; k < 4; k++)
        if (4 * w + k < n) word[8 * k +: 8] = px[4 * w + k];
      mdl[w] = word;
      mok[w] = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] q[$];
    int n;
    pix.PIX_VALID = 1'b0;
    pix.PIX_DATA  = '0;

    // Reset state
    tick();
    tick();
    chk("rst_ready", pix.PIX_READY, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_error", ERROR, 1'b0);
    chk("rst_rd", RD_DATA, 32'h0);
    RESET = 1'b1;
    tick();

    // Full words, continuous valid
    q = {};
    for (int k = 1; k <= 8; k++) q.push_back(8'(k));
    run_frame(q, 0);
    rd("w0_full", BASE, 32'h0403_0201);
    rd("w1_full", BASE + 32'd4, 32'h0807_0605);

    // Partial word and flush
    q = {};
    for (int k = 0; k < 5; k++) q.push_back(8'hA0 + 8'(k));
    run_frame(q, 0);
    rd("w0_part", BASE, 32'hA3A2_A1A0);
    rd("w1_part", BASE + 32'd4, 32'h0000_00A4);

    // Stalls every other cycle
    q = {};
    for (int k = 1; k <= 8; k++) q.push_back(8'(k));
    run_frame(q, 1);
    rd("w0_stall", BASE, 32'h0403_0201);
    rd("w1_stall", BASE + 32'd4, 32'h0807_0605);

    // Capacity exceeded: rejected, sticky error
    PIX_COUNT = 32'(4 * DEPTH + 1);
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("cap_done", DONE, 1'b1);
    chk("cap_error", ERROR, 1'b1);
    chk("cap_busy", BUSY, 1'b0);
    pix.PIX_VALID = 1'b1;
    pix.PIX_DATA  = 8'h5A;
    tick();
    tick();
    pix.PIX_VALID = 1'b0;
    chk("cap_sticky", ERROR, 1'b1);
    chk("cap_ready", pix.PIX_READY, 1'b0);
    sweep();

    // Zero-length frame
    PIX_COUNT = 32'd0;
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("zero_done", DONE, 1'b1);
    chk("zero_error", ERROR, 1'b0);
    chk("zero_busy", BUSY, 1'b0);
`ifdef MEM_PIC_WRITER_CHECKSUM_EN
    chk("zero_sum", CHECKSUM, 32'h0);
`endif

    // Exactly full capacity, then random frames with random stalls
    for (int f = 0; f < 5; f++) begin
      n = (f == 0) ? 4 * DEPTH : $urandom_range(1, 4 * DEPTH);
      q = {};
      for (int k = 0; k < n; k++) q.push_back(8'($urandom));
      run_frame(q, (f == 0) ? 0 : 2);
      sweep();
    end

    // Readback sweep, step 4, 9 reads
    for (int w = 0; w < 9; w++) rd("sweep9", BASE + 32'(4 * w), mdl[w]);
    rd("sweep_end", BASE + 32'(4 * DEPTH), 32'h0);

    // Reset mid-frame after 6 of 8 pixels
    q = {};
    for (int k = 0; k < 8; k++) q.push_back(8'($urandom));
    PIX_COUNT = 32'd8;
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 0; k < 6; k++) begin
      pix.PIX_VALID = 1'b1;
      pix.PIX_DATA  = q[k];
      tick();
    end
    pix.PIX_DATA = q[6];
    RESET = 1'b0;
    tick();
    pix.PIX_VALID = 1'b0;
    chk("mid_busy", BUSY, 1'b0);
    chk("mid_done", DONE, 1'b0);
    chk("mid_ready", pix.PIX_READY, 1'b0);
`ifdef MEM_PIC_WRITER_CHECKSUM_EN
    chk("mid_sum", CHECKSUM, 32'h0);
`endif
    RESET = 1'b1;
    mdl[0] = {q[3], q[2], q[1], q[0]};
    mok[0] = 1'b1;
    tick();
    sweep();

    // Refill from word 0
    q = {};
    for (int k = 0; k < 4; k++) q.push_back(8'($urandom));
    run_frame(q, 2);
    rd("refill_w0", BASE, {q[3], q[2], q[1], q[0]});
    sweep();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
